button_conditioner: RTL and testbench
=====================================

Name: button_conditioner

Overview:
- Upstream stage between the board push-button pins and the BSV top-level button inputs (buttons_bup_1, buttons_bleft_1, buttons_bright_1, buttons_bdown_1).
- Synchronises raw mechanical button inputs into CLK and debounces each one independently.
- Produces a clean level per button, plus single-cycle press, release and auto-repeat pulses for the application logic.

Parameters:
- N_BTN, 5, number of button channels. Channel order: 0=up, 1=left, 2=right, 3=down, 4=centre.
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required to accept a new level (10 ms at 100 MHz). Must be ≥ 2.
- DB_W, 20, debounce counter width. Must satisfy 2^DB_W ≥ DEBOUNCE_CYCLES.
- HOLD_CYCLES, 50000000, cycles from press pulse to first repeat pulse. Must be ≥ 2.
- REPEAT_CYCLES, 10000000, cycles between subsequent repeat pulses. Must be ≥ 2.
- RPT_W, 26, repeat counter width. Must hold max(HOLD_CYCLES, REPEAT_CYCLES).

Ports:
- CLK  in  1  system clock; all state is on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- btn_raw  in  N_BTN  raw pad inputs, asynchronous to CLK, 1 = pressed.
- btn_level  out  N_BTN  debounced level.
- btn_press  out  N_BTN  one-cycle pulse when the debounced level rises.
- btn_release  out  N_BTN  one-cycle pulse when the debounced level falls.
- btn_repeat  out  N_BTN  one-cycle auto-repeat pulse while held.

Behaviour:
- Reset: RST high asynchronously clears all state and all outputs to 0. Affected state: synchroniser flops, debounce counters, stable levels, FSMs, repeat counters. Outputs are 0 while RST is high; operation starts on the first CLK edge after RST falls.
- Synchroniser: 2 flops per channel (s1 ← btn_raw, s2 ← s1). Only s2 is used downstream.
- Debounce, per channel, with stable level st and counter dcnt:
  - If s2 == st, dcnt ← 0.
  - Else, if dcnt == DEBOUNCE_CYCLES-1: st ← s2 and dcnt ← 0.
  - Else: dcnt ← dcnt+1.
  - Any glitch shorter than DEBOUNCE_CYCLES clears dcnt; st does not change.
- Outputs are registered:
  - btn_level = st.
  - btn_press is high for exactly the one cycle in which st becomes 1, coincident with btn_level rising.
  - btn_release behaves the same way for the 1→0 transition.
- Latency: raw held steady from the first sampling edge E → btn_level and the pulse change at edge E+DEBOUNCE_CYCLES+1, i.e. visible in the (DEBOUNCE_CYCLES+2)th cycle after E.
- Repeat FSM, per channel; states IDLE, HOLD, RPT; counter rcnt:
  - IDLE: in the cycle btn_press asserts, go to HOLD with rcnt ← 1.
  - HOLD: rcnt increments each cycle. When rcnt == HOLD_CYCLES: assert btn_repeat that cycle, go to RPT, rcnt ← 1.
  - RPT: rcnt increments each cycle. When rcnt == REPEAT_CYCLES: assert btn_repeat, rcnt ← 1.
  - From HOLD or RPT: the cycle st becomes 0, go to IDLE and clear rcnt. btn_repeat is never asserted in the same cycle as btn_release.
  - Resulting timing: first repeat exactly HOLD_CYCLES cycles after the press pulse, then every REPEAT_CYCLES cycles.
- Channels are fully independent. Simultaneous presses on several channels produce simultaneous pulses.
- btn_press, btn_release and btn_repeat are mutually exclusive per channel in any cycle.
- Reset mid-debounce or mid-repeat: all progress is discarded, with no pulse on reset deassertion. A button still held after reset is re-debounced and produces a fresh btn_press.

Test Plan:
Bench parameters: DEBOUNCE_CYCLES=4, HOLD_CYCLES=10, REPEAT_CYCLES=3, N_BTN=5.
1. Reset: RST=1 with btn_raw=5'b11111 → all outputs 0 throughout. Release RST with raw held → btn_level=5'b11111 and btn_press=5'b11111 for one cycle, 6 cycles after the first sampling edge.
2. Clean press on channel 0 sampled at edge E → btn_level[0] rises and btn_press[0]=1 in cycle E+6 only. Raw low at edge F → btn_release[0] pulses in cycle F+6, btn_level[0]=0.
3. Bounce: channel 1 raw toggles 1,0,1,1,0,1 then holds 1 → no pulse until 4 consecutive s2 highs. Exactly one btn_press[1]. A 3-cycle high glitch produces no btn_press.
4. Auto-repeat: channel 2 held, press pulse at cycle P → btn_repeat[2] at P+10, P+13, P+16. Release debounced at P+18 → btn_release[2] at P+18, no further repeats.
5. Simultaneous: channels 3 and 4 pressed on the same edge → both press pulses in the same cycle. Channel 3 released mid-HOLD → channel 4 repeat timing unaffected.
6. Reset mid-repeat: RST pulsed at P+12 with channel 2 held → no repeat at P+13. After reset, a new btn_press[2] follows 6 cycles after the first sampling edge.

Source files
------------

// File: rtl/button_conditioner.sv
// Push-button front end: per-channel 2-flop synchroniser, counter debounce,
// registered press/release edge pulses and a hold-then-repeat pulse generator.

module button_channel #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int DB_W            = 20,
    parameter int HOLD_CYCLES     = 50000000,
    parameter int REPEAT_CYCLES   = 10000000,
    parameter int RPT_W           = 26
) (
    input  logic CLK,
    input  logic RST,
    input  logic raw,
    output logic level,
    output logic press,
    output logic rel,
    output logic rpt
);
    typedef enum logic [1:0] {IDLE, HOLD, RPT} state_t;

    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RPT_W-1:0] HOLD_CNT = RPT_W'(HOLD_CYCLES);
    localparam logic [RPT_W-1:0] RPT_CNT  = RPT_W'(REPEAT_CYCLES);

    logic             s1, s2, st;
    logic [DB_W-1:0]  dcnt;
    logic [RPT_W-1:0] rcnt;
    state_t           state;
    logic             accept, rise, fall;

    // accept: this edge commits s2 as the new stable level
    always_comb begin
        accept = (s2 != st) && (dcnt == DB_LAST);
        rise   = accept && s2;
        fall   = accept && !s2;
    end

    assign level = st;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            st    <= 1'b0;
            dcnt  <= '0;
            press <= 1'b0;
            rel   <= 1'b0;
            rpt   <= 1'b0;
            rcnt  <= '0;
            state <= IDLE;
        end else begin
            s1    <= raw;
            s2    <= s1;
            press <= rise;
            rel   <= fall;
            rpt   <= 1'b0;

            if (s2 == st)
                dcnt <= '0;
            else if (accept) begin
                st   <= s2;
                dcnt <= '0;
            end else
                dcnt <= dcnt + DB_W'(1);

            // The counter starts on the same edge the press pulse is registered,
            // so rcnt == N lines up with the Nth cycle after the press pulse.
            case (state)
                IDLE: begin
                    if (rise) begin
                        state <= HOLD;
                        rcnt  <= RPT_W'(1);
                    end
                end
                HOLD: begin
                    if (fall) begin
                        state <= IDLE;
                        rcnt  <= '0;
                    end else if (rcnt == HOLD_CNT) begin
                        rpt   <= 1'b1;
                        state <= RPT;
                        rcnt  <= RPT_W'(1);
                    end else
                        rcnt <= rcnt + RPT_W'(1);
                end
                RPT: begin
                    if (fall) begin
                        state <= IDLE;
                        rcnt  <= '0;
                    end else if (rcnt == RPT_CNT) begin
                        rpt  <= 1'b1;
                        rcnt <= RPT_W'(1);
                    end else
                        rcnt <= rcnt + RPT_W'(1);
                end
                default: begin
                    state <= IDLE;
                    rcnt  <= '0;
                end
            endcase
        end
    end
endmodule

module button_conditioner #(
    parameter int N_BTN           = 5,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int DB_W            = 20,
    parameter int HOLD_CYCLES     = 50000000,
    parameter int REPEAT_CYCLES   = 10000000,
    parameter int RPT_W           = 26
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_repeat
);
    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        button_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .DB_W           (DB_W),
            .HOLD_CYCLES    (HOLD_CYCLES),
            .REPEAT_CYCLES  (REPEAT_CYCLES),
            .RPT_W          (RPT_W)
        ) u_ch (
            .CLK  (CLK),
            .RST  (RST),
            .raw  (btn_raw[i]),
            .level(btn_level[i]),
            .press(btn_press[i]),
            .rel  (btn_release[i]),
            .rpt  (btn_repeat[i])
        );
    end
endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with short debounce/hold/repeat times.

module tb_button_conditioner;
    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [4:0] btn_raw = '0;
    logic [4:0] btn_level, btn_press, btn_release, btn_repeat;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       rst;
        logic [4:0] raw;
        logic [4:0] lvl, prs, rel, rpt;
        string      nm;
    } vec_t;

    vec_t tbl[$];

    button_conditioner #(
        .N_BTN(5), .DEBOUNCE_CYCLES(4), .DB_W(3),
        .HOLD_CYCLES(10), .REPEAT_CYCLES(3), .RPT_W(4)
    ) dut (
        .CLK(CLK), .RST(RST), .btn_raw(btn_raw),
        .btn_level(btn_level), .btn_press(btn_press),
        .btn_release(btn_release), .btn_repeat(btn_repeat)
    );

    always #5 CLK = ~CLK;

    function automatic void add(input logic r, input logic [4:0] raw,
                                input logic [4:0] l, p, rl, rp, input string nm);
        vec_t v;
        v.rst = r; v.raw = raw; v.lvl = l; v.prs = p; v.rel = rl; v.rpt = rp; v.nm = nm;
        tbl.push_back(v);
    endfunction

    // Drive one cycle's inputs, clock once, then compare away from the edge.
    task automatic cyc(input logic r, input logic [4:0] raw,
                       input logic [4:0] l, p, rl, rp, input string nm);
        RST = r;
        btn_raw = raw;
        @(posedge CLK);
        #1;
        checks++;
        if ({btn_level, btn_press, btn_release, btn_repeat} !== {l, p, rl, rp}) begin
            errors++;
            $display("FAIL %s: got lvl=%b prs=%b rel=%b rpt=%b want lvl=%b prs=%b rel=%b rpt=%b",
                     nm, btn_level, btn_press, btn_release, btn_repeat, l, p, rl, rp);
        end
    endtask

    initial begin
        logic [4:0] m;
        logic [4:0] m3, m4;
        logic [11:0] bounce;

        // Reset held with all buttons down: outputs stay 0.
        #1;
        checks++;
        if ({btn_level, btn_press, btn_release, btn_repeat} !== 20'd0) begin
            errors++;
            $display("FAIL reset_async: got %b want 0",
                     {btn_level, btn_press, btn_release, btn_repeat});
        end
        for (int i = 0; i < 3; i++) add(1'b1, 5'b11111, '0, '0, '0, '0, $sformatf("reset%0d", i));

        // All channels held through reset release, then all released.
        // Clean single press/release on channel 0.
        for (int ph = 0; ph < 2; ph++) begin
            m = (ph == 0) ? 5'b11111 : 5'b00001;
            for (int k = 1; k <= 14; k++)
                add(1'b0, (k < 8) ? m : 5'b0,
                    (k >= 6 && k < 13) ? m : 5'b0,
                    (k == 6)  ? m : 5'b0,
                    (k == 13) ? m : 5'b0,
                    5'b0, $sformatf("clean%0d_k%0d", ph, k));
        end

        // Channel 1 bounces 1,0,1,1,0,1 then settles high; released at step 13.
        bounce = 12'b1111_1110_1101;
        for (int k = 1; k <= 19; k++)
            add(1'b0, (k <= 12 && bounce[k-1]) ? 5'b00010 : 5'b0,
                (k >= 11 && k < 18) ? 5'b00010 : 5'b0,
                (k == 11) ? 5'b00010 : 5'b0,
                (k == 18) ? 5'b00010 : 5'b0,
                5'b0, $sformatf("bounce_k%0d", k));

        // Three-cycle glitch on channel 1 must be rejected.
        for (int k = 1; k <= 10; k++)
            add(1'b0, (k <= 3) ? 5'b00010 : 5'b0, '0, '0, '0, '0, $sformatf("glitch_k%0d", k));

        foreach (tbl[i])
            cyc(tbl[i].rst, tbl[i].raw, tbl[i].lvl, tbl[i].prs, tbl[i].rel, tbl[i].rpt, tbl[i].nm);

        // Auto-repeat on channel 2: press at 6, repeats 16/19/22, release 24.
        m = 5'b00100;
        for (int k = 1; k <= 30; k++)
            cyc(1'b0, (k < 19) ? m : 5'b0,
                (k >= 6 && k < 24) ? m : 5'b0,
                (k == 6)  ? m : 5'b0,
                (k == 24) ? m : 5'b0,
                (k == 16 || k == 19 || k == 22) ? m : 5'b0,
                $sformatf("repeat_k%0d", k));

        // Channels 3/4 together; 3 released mid-hold, 4 released on a repeat slot.
        m3 = 5'b01000; m4 = 5'b10000;
        for (int k = 1; k <= 32; k++)
            cyc(1'b0, ((k < 8) ? m3 : 5'b0) | ((k < 23) ? m4 : 5'b0),
                ((k >= 6 && k < 13) ? m3 : 5'b0) | ((k >= 6 && k < 28) ? m4 : 5'b0),
                (k == 6) ? (m3 | m4) : 5'b0,
                ((k == 13) ? m3 : 5'b0) | ((k == 28) ? m4 : 5'b0),
                (k == 16 || k == 19 || k == 22 || k == 25) ? m4 : 5'b0,
                $sformatf("simul_k%0d", k));

        // Reset in the middle of repeating: no repeat at 19, fresh press at 24.
        m = 5'b00100;
        for (int k = 1; k <= 33; k++)
            cyc(k == 18, (k < 27) ? m : 5'b0,
                ((k >= 6 && k < 18) || (k >= 24 && k < 32)) ? m : 5'b0,
                (k == 6 || k == 24) ? m : 5'b0,
                (k == 32) ? m : 5'b0,
                (k == 16) ? m : 5'b0,
                $sformatf("rstmid_k%0d", k));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
